// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bundle: two writeback requesters, the registered
// write-port drive, and the two read-channel forwarding compares.
interface rf_wr_arbiter_if #(
  parameter int N_DATA = 32,
  parameter int N_ADDR = 5
) ();

  logic              req_0_valid;
  logic [N_ADDR-1:0] req_0_addr;
  logic [N_DATA-1:0] req_0_data;
  logic              req_0_ready;

  logic              req_1_valid;
  logic [N_ADDR-1:0] req_1_addr;
  logic [N_DATA-1:0] req_1_data;
  logic              req_1_ready;

  logic              w_en;
  logic [N_ADDR-1:0] addr_w;
  logic [N_DATA-1:0] w_data;

  logic [N_ADDR-1:0] fwd_addr_1;
  logic              fwd_hit_1;
  logic [N_DATA-1:0] fwd_data_1;
  logic [N_ADDR-1:0] fwd_addr_2;
  logic              fwd_hit_2;
  logic [N_DATA-1:0] fwd_data_2;

  // Requesters plus register-file side.
  modport master (
    output req_0_valid, req_0_addr, req_0_data,
    input  req_0_ready,
    output req_1_valid, req_1_addr, req_1_data,
    input  req_1_ready,
    input  w_en, addr_w, w_data,
    output fwd_addr_1, fwd_addr_2,
    input  fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2
  );

  // Arbiter side.
  modport slave (
    input  req_0_valid, req_0_addr, req_0_data,
    output req_0_ready,
    input  req_1_valid, req_1_addr, req_1_data,
    output req_1_ready,
    output w_en, addr_w, w_data,
    input  fwd_addr_1, fwd_addr_2,
    output fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2
  );

endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// load writeback, with a registered write drive and per-read-channel bypass.
module rf_wr_arbiter #(
  parameter int N_DATA = 32,
  parameter int N_ADDR = 5,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             arst,
  rf_wr_arbiter_if.slave   bus,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int N_REQ = 2;
  localparam int N_CH  = 2;

  logic [N_REQ-1:0] req_valid;
  logic [N_ADDR-1:0] req_addr [N_REQ];
  logic [N_DATA-1:0] req_data [N_REQ];
  logic [N_REQ-1:0] gnt;

  logic              last_grant_reg;
  logic              w_en_reg;
  logic [N_ADDR-1:0] addr_w_reg;
  logic [N_DATA-1:0] w_data_reg;
  logic [CNT_W-1:0]  drop_cnt_reg;

  logic              xfer;
  logic              sel_idx;
  logic [N_ADDR-1:0] sel_addr;
  logic [N_DATA-1:0] sel_data;

  assign req_valid   = {bus.req_1_valid, bus.req_0_valid};
  assign req_addr[0] = bus.req_0_addr;
  assign req_addr[1] = bus.req_1_addr;
  assign req_data[0] = bus.req_0_data;
  assign req_data[1] = bus.req_1_data;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    gnt = '0;
    if (arst) begin
      gnt[0] = req_valid[0] & (~req_valid[1] | last_grant_reg);
      gnt[1] = req_valid[1] & (~req_valid[0] | ~last_grant_reg);
    end
  end

  assign bus.req_0_ready = gnt[0];
  assign bus.req_1_ready = gnt[1];

  assign xfer     = |gnt;
  assign sel_idx  = gnt[1];
  assign sel_addr = req_addr[sel_idx];
  assign sel_data = req_data[sel_idx];

  always_ff @(posedge i_clk) begin
    if (!arst) begin
      last_grant_reg <= 1'b1;
      w_en_reg       <= 1'b0;
      addr_w_reg     <= '0;
      w_data_reg     <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      w_en_reg <= 1'b0;
      if (xfer) begin
        last_grant_reg <= sel_idx;
        if (sel_addr != '0) begin
          w_en_reg   <= 1'b1;
          addr_w_reg <= sel_addr;
          w_data_reg <= sel_data;
        end else if (drop_cnt_reg != {CNT_W{1'b1}}) begin
          // Register 0 is hardwired; acknowledge the write but only count it.
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.w_en   = w_en_reg;
  assign bus.addr_w = addr_w_reg;
  assign bus.w_data = w_data_reg;
  assign drop_cnt   = drop_cnt_reg;

  logic [N_ADDR-1:0] fwd_addr [N_CH];
  logic              fwd_hit  [N_CH];
  logic [N_DATA-1:0] fwd_data [N_CH];

  assign fwd_addr[0] = bus.fwd_addr_1;
  assign fwd_addr[1] = bus.fwd_addr_2;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fwd
      assign fwd_hit[gi]  = w_en_reg & (addr_w_reg == fwd_addr[gi]) & (addr_w_reg != '0);
      assign fwd_data[gi] = fwd_hit[gi] ? w_data_reg : '0;
    end
  endgenerate

  assign bus.fwd_hit_1  = fwd_hit[0];
  assign bus.fwd_data_1 = fwd_data[0];
  assign bus.fwd_hit_2  = fwd_hit[1];
  assign bus.fwd_data_2 = fwd_data[1];

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: reset, single write, round-robin tie,
// register-0 drop with saturation, forwarding, mid-run reset, idle hold.
module tb_rf_wr_arbiter;

  localparam int N_DATA = 32;
  localparam int N_ADDR = 5;
  localparam int CNT_W  = 2;

  logic             i_clk;
  logic             arst;
  logic [CNT_W-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  rf_wr_arbiter_if #(.N_DATA(N_DATA), .N_ADDR(N_ADDR)) bus ();

  rf_wr_arbiter #(.N_DATA(N_DATA), .N_ADDR(N_ADDR), .CNT_W(CNT_W)) dut (
    .i_clk    (i_clk),
    .arst     (arst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int i0;
    int i1;
    int exp_addr [8];
    exp_addr = '{1, 9, 2, 10, 3, 11, 4, 12};

    arst = 1'b0;
    bus.req_0_valid = 1'b1; bus.req_0_addr = 5'd5; bus.req_0_data = 32'h1111_1111;
    bus.req_1_valid = 1'b1; bus.req_1_addr = 5'd6; bus.req_1_data = 32'h2222_2222;
    bus.fwd_addr_1 = '0; bus.fwd_addr_2 = '0;

    // Reset held two cycles; ready must stay low despite valid.
    tick();
    chk("rst_rdy0", bus.req_0_ready, 0);
    chk("rst_rdy1", bus.req_1_ready, 0);
    tick();
    chk("rst_w_en", bus.w_en, 0);
    chk("rst_addr_w", bus.addr_w, 0);
    chk("rst_w_data", bus.w_data, 0);
    chk("rst_drop", drop_cnt, 0);

    // Single request.
    arst = 1'b1;
    bus.req_1_valid = 1'b0;
    bus.req_0_addr = 5'd5; bus.req_0_data = 32'hDEAD_BEEF;
    #1;
    chk("single_rdy0", bus.req_0_ready, 1);
    chk("single_rdy1", bus.req_1_ready, 0);
    tick();
    bus.req_0_valid = 1'b0;
    chk("single_w_en", bus.w_en, 1);
    chk("single_addr_w", bus.addr_w, 5);
    chk("single_w_data", bus.w_data, 32'hDEAD_BEEF);
    #1;
    chk("single_rdy_off", bus.req_0_ready, 0);
    tick();
    chk("single_w_en_off", bus.w_en, 0);

    // Register-0 writes: acknowledged, dropped, counted up to saturation at 3.
    bus.req_1_valid = 1'b1; bus.req_1_addr = 5'd0; bus.req_1_data = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      #1;
      $display("zero write %0d: rdy1=%0b", k, bus.req_1_ready);
      chk("zero_rdy1", bus.req_1_ready, 1);
      tick();
      chk("zero_w_en", bus.w_en, 0);
      chk("zero_drop", drop_cnt, (k < 3) ? k + 1 : 3);
    end
    bus.req_1_valid = 1'b0;

    // Tie: last grant went to requester 1, so grants run 0,1,0,1,...
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      bus.req_0_valid = (i0 < 4);
      bus.req_0_addr  = 5'(1 + i0);
      bus.req_0_data  = 32'h0A00_0000 + 32'(i0);
      bus.req_1_valid = (i1 < 4);
      bus.req_1_addr  = 5'(9 + i1);
      bus.req_1_data  = 32'h0B00_0000 + 32'(i1);
      #1;
      chk("rr_rdy0", bus.req_0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_rdy1", bus.req_1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      $display("rr transfer %0d: addr_w=%0d w_data=%h", k, bus.addr_w, bus.w_data);
      chk("rr_w_en", bus.w_en, 1);
      chk("rr_addr_w", bus.addr_w, exp_addr[k]);
      chk("rr_w_data", bus.w_data, (k % 2 == 0) ? 32'h0A00_0000 + 32'(k / 2)
                                                 : 32'h0B00_0000 + 32'(k / 2));
      if (k % 2 == 0) i0++; else i1++;
    end
    bus.req_0_valid = 1'b0; bus.req_1_valid = 1'b0;

    // Forwarding after a write to r7.
    bus.req_0_valid = 1'b1; bus.req_0_addr = 5'd7; bus.req_0_data = 32'hA5A5_A5A5;
    tick();
    bus.req_0_valid = 1'b0;
    bus.fwd_addr_1 = 5'd7; bus.fwd_addr_2 = 5'd7;
    #1;
    chk("fwd_hit_1", bus.fwd_hit_1, 1);
    chk("fwd_hit_2", bus.fwd_hit_2, 1);
    chk("fwd_data_1", bus.fwd_data_1, 32'hA5A5_A5A5);
    chk("fwd_data_2", bus.fwd_data_2, 32'hA5A5_A5A5);
    bus.fwd_addr_2 = 5'd6;
    #1;
    chk("fwd_miss_hit_2", bus.fwd_hit_2, 0);
    chk("fwd_miss_data_2", bus.fwd_data_2, 0);
    chk("fwd_keep_hit_1", bus.fwd_hit_1, 1);
    tick();
    chk("fwd_stale_hit_1", bus.fwd_hit_1, 0);

    // Reset mid-operation; the pointer favoured requester 1 before it.
    arst = 1'b0;
    bus.req_0_valid = 1'b1; bus.req_0_addr = 5'd3; bus.req_0_data = 32'h0000_0333;
    #1;
    chk("mrst_rdy0", bus.req_0_ready, 0);
    tick();
    chk("mrst_w_en", bus.w_en, 0);
    chk("mrst_addr_w", bus.addr_w, 0);
    chk("mrst_drop", drop_cnt, 0);
    arst = 1'b1;
    bus.req_1_valid = 1'b1; bus.req_1_addr = 5'd13; bus.req_1_data = 32'h0000_0D0D;
    #1;
    chk("mrst_tie_rdy0", bus.req_0_ready, 1);
    chk("mrst_tie_rdy1", bus.req_1_ready, 0);
    tick();
    bus.req_0_valid = 1'b0;
    chk("mrst_first_addr", bus.addr_w, 3);
    #1;
    chk("mrst_second_rdy1", bus.req_1_ready, 1);
    tick();
    bus.req_1_valid = 1'b0;
    chk("mrst_second_addr", bus.addr_w, 13);
    chk("mrst_second_data", bus.w_data, 32'h0000_0D0D);

    // Idle hold after a write to r8.
    tick();
    bus.req_0_valid = 1'b1; bus.req_0_addr = 5'd8; bus.req_0_data = 32'h0000_0888;
    tick();
    bus.req_0_valid = 1'b0;
    chk("idle_w_en_first", bus.w_en, 1);
    chk("idle_addr_first", bus.addr_w, 8);
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("idle cycle %0d: w_en=%0b addr_w=%0d", c, bus.w_en, bus.addr_w);
      chk("idle_w_en", bus.w_en, 0);
      chk("idle_addr_w", bus.addr_w, 8);
      chk("idle_w_data", bus.w_data, 32'h0000_0888);
    end
    for (int a = 0; a < 32; a++) begin
      bus.fwd_addr_1 = 5'(a);
      bus.fwd_addr_2 = 5'(31 - a);
      #1;
      chk("idle_hit_1", bus.fwd_hit_1, 0);
      chk("idle_hit_2", bus.fwd_hit_2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single write port of the MIPS register file between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load).
- Each requester uses a valid/ready handshake. Arbitration is round-robin. The write-port drive (w_en/addr_w/w_data) is registered.
- Gives each of the two register-file read channels a forwarding compare, so a read in the same cycle as a write can bypass the stale stored value.
- Drops writes to register 0 and counts them.

Parameters:
N_DATA  32  data width of a register / write bus
N_ADDR  5   register address width (32 registers)
CNT_W   8   width of the saturating dropped-write counter

Ports:
i_clk        in   1       clock; all state updates on posedge
arst         in   1       reset, synchronous, active-low (0 at posedge = reset)
req_0_valid  in   1       ALU write request valid
req_0_addr   in   N_ADDR  ALU destination register
req_0_data   in   N_DATA  ALU write data
req_0_ready  out  1       ALU request accepted this cycle
req_1_valid  in   1       load write request valid
req_1_addr   in   N_ADDR  load destination register
req_1_data   in   N_DATA  load write data
req_1_ready  out  1       load request accepted this cycle
w_en         out  1       to register file write enable
addr_w       out  N_ADDR  to register file write address
w_data       out  N_DATA  to register file write data
fwd_addr_1   in   N_ADDR  read channel 1 address (same as regfile addr_r_1)
fwd_hit_1    out  1       channel 1 must use fwd_data_1
fwd_data_1   out  N_DATA  bypass data for channel 1
fwd_addr_2   in   N_ADDR  read channel 2 address
fwd_hit_2    out  1       channel 2 must use fwd_data_2
fwd_data_2   out  N_DATA  bypass data for channel 2
drop_cnt     out  CNT_W   number of accepted writes to register 0, saturating

Behaviour:
- Reset (arst=0 at posedge):
  - w_en=0, addr_w=0, w_data=0, drop_cnt=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - While arst=0, req_0_ready=req_1_ready=0.
  - Reset mid-operation: a write accepted in the reset cycle is discarded, and w_en=0 in the following cycle.
- Grant (combinational, arst=1):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester other than last_grant.
  - Neither valid: no grant.
  - req_x_ready = grant_x. Ready never asserts without the matching valid.
- Transfer occurs when valid & ready. Requesters hold valid/addr/data stable until their transfer; deasserting earlier is a protocol error and undefined.
- On a transfer, last_grant is set to the granted index. With no transfer, last_grant holds.
- Output stage, latency 1 cycle from transfer to write-port drive:
  - Transfer with addr!=0: next cycle w_en=1, addr_w/w_data = granted addr/data.
  - Transfer with addr==0: next cycle w_en=0. The request is still acknowledged. drop_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - No transfer: next cycle w_en=0; addr_w and w_data hold their previous values.
- Throughput: one write per cycle. Back-to-back transfers from the same requester are allowed when the other requester is idle.
- Forwarding (combinational from registered outputs):
  - fwd_hit_k = w_en & (addr_w == fwd_addr_k) & (addr_w != 0).
  - fwd_data_k = fwd_hit_k ? w_data : 0.
  - Both channels may hit the same address simultaneously.
- Starvation bound: with both requesters continuously valid, grants alternate strictly 0,1,0,1...

Test Plan:
- Reset, then a single request: hold arst=0 for 2 cycles, then raise arst; req_0 valid with addr=5, data=0xDEADBEEF → req_0_ready=1 that cycle; next cycle w_en=1, addr_w=5, w_data=0xDEADBEEF; following cycle w_en=0.
- Tie and round-robin: both valid continuously for 4 cycles (req_0 addr 1..4, req_1 addr 9..12) → grants in order 0,1,0,1; w_en asserted 4 consecutive cycles; addr_w sequence 1,9,2,10.
- Zero register: req_1 addr=0, data=0x12345678 → req_1_ready=1; next cycle w_en=0; drop_cnt 0→1. With CNT_W=2, 5 such writes → drop_cnt saturates at 3.
- Forwarding: after a transfer with addr=7, data=0xA5A5A5A5, set fwd_addr_1=7, fwd_addr_2=7 → fwd_hit_1=fwd_hit_2=1, both fwd_data=0xA5A5A5A5. fwd_addr_2=6 → fwd_hit_2=0, fwd_data_2=0.
- Reset mid-operation: transfer of addr=3 in the same cycle arst=0 → next cycle w_en=0, addr_w=0; then both requesters valid → req_0 granted first.
- Idle hold: no valid for 3 cycles after a write to addr=8 → w_en=0, addr_w stays 8, fwd_hit_k=0 for all addresses.
